// File: rtl/sdram_client_arbiter_if.sv
// sdram_client_arbiter_if: single-word bridge port between the arbiter (master) and the SDRAM bridge (slave)
interface sdram_client_arbiter_if #(
  parameter int AW = 22,
  parameter int DW = 128
);
  logic [AW-1:0]   addr;
  logic [DW/8-1:0] be;
  logic            read;
  logic            write;
  logic [DW-1:0]   wrdata;
  logic            ack;
  logic [DW-1:0]   rddata;
  modport master (output addr, be, read, write, wrdata, input ack, rddata);
  modport slave  (input addr, be, read, write, wrdata, output ack, rddata);
endinterface

// File: rtl/sdram_client_arbiter.sv
// sdram_client_arbiter: fixed-priority real-time clients plus round-robin others onto one SDRAM bridge port
module sdram_client_arbiter #(
  parameter int N_CLIENTS = 7,
  parameter int N_RT      = 2,
  parameter int AW        = 22,
  parameter int DW        = 128,
  parameter int BEW       = DW/8
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CLIENTS-1:0]     cl_rd,
  input  logic [N_CLIENTS-1:0]     cl_wr,
  input  logic [N_CLIENTS*AW-1:0]  cl_addr,
  input  logic [N_CLIENTS*DW-1:0]  cl_wrdata,
  input  logic [N_CLIENTS*BEW-1:0] cl_be,
  output logic [N_CLIENTS-1:0]     cl_ac,
  output logic [N_CLIENTS-1:0]     cl_wait,
  output logic [DW-1:0]            cl_rddata,
  sdram_client_arbiter_if.master   br,
  output logic                     busy,
  output logic [3:0]               grant_idx
);
  localparam int N_RR = N_CLIENTS - N_RT;
  localparam int IW   = $clog2(N_CLIENTS);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t               state;
  logic [3:0]           rr_ptr;
  logic [3:0]           win;
  logic                 rt_hit;
  logic [N_CLIENTS-1:0] req;
  logic                 sel_wr;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_data;
  logic [BEW-1:0]       sel_be;
  assign req      = cl_rd | cl_wr;
  assign cl_wait  = req & ~cl_ac;
  assign busy     = state != IDLE;
  assign sel_wr   = |(cl_wr & (N_CLIENTS'(1) << win));
  assign sel_addr = AW'(cl_addr >> (int'(win) * AW));
  assign sel_data = DW'(cl_wrdata >> (int'(win) * DW));
  assign sel_be   = BEW'(cl_be >> (int'(win) * BEW));
  // Later loop iterations override earlier ones, so the scans run from lowest to highest precedence.
  always_comb begin
    win    = '0;
    rt_hit = 1'b0;
    for (int k = N_RR; k >= 1; k--)
      if (req[IW'(N_RT + (int'(rr_ptr) - N_RT + k) % N_RR)]) win = 4'(N_RT + (int'(rr_ptr) - N_RT + k) % N_RR);
    for (int i = N_RT - 1; i >= 0; i--)
      if (req[IW'(i)]) begin
        win    = 4'(i);
        rt_hit = 1'b1;
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      br.read   <= 1'b0;
      br.write  <= 1'b0;
      br.addr   <= '0;
      br.be     <= '0;
      br.wrdata <= '0;
      cl_rddata <= '0;
      cl_ac     <= '0;
      grant_idx <= '0;
      rr_ptr    <= 4'(N_CLIENTS - 1);
    end else begin
      unique case (state)
        IDLE: begin
          cl_ac <= '0;
          if (|req) begin
            state     <= ISSUE;
            grant_idx <= win;
            rr_ptr    <= rt_hit ? rr_ptr : win;
            br.read   <= ~sel_wr;
            br.write  <= sel_wr;
            br.addr   <= sel_addr;
            br.be     <= sel_wr ? sel_be : '1;
            br.wrdata <= sel_data;
          end
        end
        ISSUE: begin
          if (br.ack) begin
            state    <= DONE;
            br.read  <= 1'b0;
            br.write <= 1'b0;
            cl_ac    <= N_CLIENTS'(1) << grant_idx;
            if (br.read) cl_rddata <= br.rddata;
          end
        end
        DONE: begin
          cl_ac <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_client_arbiter.sv
// tb_sdram_client_arbiter: table-driven single transactions plus priority, round-robin and reset sequences
module tb_sdram_client_arbiter;
  localparam int N = 7, NRT = 2, AW = 22, DW = 128, BEW = DW/8;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] cl_rd = '0, cl_wr = '0, cl_ac, cl_wait;
  logic [N*AW-1:0] cl_addr = '0;
  logic [N*DW-1:0] cl_wrdata = '0;
  logic [N*BEW-1:0] cl_be = '0;
  logic [DW-1:0] cl_rddata;
  logic busy;
  logic [3:0] grant_idx;
  int checks = 0, errors = 0;
  int lat = 1;
  bit ack_en = 1'b1;
  logic [DW-1:0] rdata_v = '0;
  sdram_client_arbiter_if #(.AW(AW), .DW(DW)) br ();
  sdram_client_arbiter #(.N_CLIENTS(N), .N_RT(NRT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_addr(cl_addr),
    .cl_wrdata(cl_wrdata), .cl_be(cl_be), .cl_ac(cl_ac), .cl_wait(cl_wait),
    .cl_rddata(cl_rddata), .br(br.master), .busy(busy), .grant_idx(grant_idx)
  );
  always #10 clk = ~clk;
  // Bridge model: acks on the lat-th consecutive strobe cycle.
  initial begin
    int cnt;
    cnt = 0;
    br.ack = 1'b0;
    br.rddata = '0;
    forever begin
      @(posedge clk); #1;
      cnt = (br.read || br.write) ? cnt + 1 : 0;
      br.ack = ack_en && (br.read || br.write) && cnt == lat;
      br.rddata = br.ack ? rdata_v : '0;
    end
  end
  always @(negedge clk) if (!reset) begin
    checks++;
    if ((br.read && br.write) || $countones(cl_ac) > 1 || (!busy && (br.read || br.write))) begin
      errors++;
      $display("FAIL invariant: read=%0b write=%0b cl_ac=%b busy=%0b required one strobe, <=1 ack, no strobe when idle",
               br.read, br.write, cl_ac, busy);
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400us");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask
  task automatic set_client(input int c, input bit rd, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BEW-1:0] b);
    cl_rd[c] = rd;
    cl_wr[c] = wr;
    cl_addr[c*AW +: AW] = a;
    cl_wrdata[c*DW +: DW] = d;
    cl_be[c*BEW +: BEW] = b;
  endtask
  task automatic wait_ac(output int idx);
    idx = -1;
    for (int n = 0; n < 30 && idx < 0; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (cl_ac[i]) idx = i;
    end
    if (idx < 0) begin
      errors++;
      $display("FAIL wait_ac: no cl_ac within 30 cycles, required one");
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  typedef struct {
    int c; bit rd; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BEW-1:0] be;
    int lat; logic [DW-1:0] rdata;
    bit exp_read; bit exp_write; logic [BEW-1:0] exp_be; logic [DW-1:0] exp_rddata;
  } vec_t;
  vec_t vecs[5];
  localparam logic [DW-1:0] D_DEAD = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [DW-1:0] D_WR   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [DW-1:0] D_BAD  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [DW-1:0] D_R2   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] D_R4   = 128'hCAFE_F00D_0000_0001_8000_0000_7FFF_FFFF;
  initial begin
    int n, idx;
    int pri_tail[3] = '{6, 2, 4};
    int rr_exp[10]  = '{2, 3, 4, 5, 6, 2, 3, 4, 5, 6};
    vecs[0] = '{3, 1, 0, 22'h00100, '0, 16'h0001, 4, D_DEAD, 1, 0, 16'hFFFF, D_DEAD};
    vecs[1] = '{5, 0, 1, 22'h2AAAA, D_WR, 16'h00FF, 2, D_BAD, 0, 1, 16'h00FF, D_DEAD};
    vecs[2] = '{0, 1, 0, 22'h3FFFFF, '0, 16'h0000, 1, D_R2, 1, 0, 16'hFFFF, D_R2};
    vecs[3] = '{4, 1, 1, 22'h000001, D_WR ^ D_R2, 16'hF00F, 3, D_BAD, 0, 1, 16'hF00F, D_R2};
    vecs[4] = '{1, 1, 0, 22'h155555, '0, 16'h8001, 2, D_R4, 1, 0, 16'hFFFF, D_R4};
    do_reset();
    chk("rst_read", br.read, 0);
    chk("rst_write", br.write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ac", cl_ac, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_rddata", cl_rddata, 0);
    chk("rst_addr", br.addr, 0);
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      lat = vecs[v].lat;
      rdata_v = vecs[v].rdata;
      set_client(vecs[v].c, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be);
      @(posedge clk); #1;
      chk($sformatf("v%0d_read", v), br.read, vecs[v].exp_read);
      chk($sformatf("v%0d_write", v), br.write, vecs[v].exp_write);
      chk($sformatf("v%0d_addr", v), br.addr, vecs[v].addr);
      chk($sformatf("v%0d_be", v), br.be, vecs[v].exp_be);
      chk($sformatf("v%0d_grant", v), grant_idx, vecs[v].c);
      chk($sformatf("v%0d_wait", v), cl_wait[vecs[v].c], 1);
      if (vecs[v].exp_write) chk($sformatf("v%0d_wrdata", v), br.wrdata, vecs[v].wdata);
      n = 1;
      while (!cl_ac[vecs[v].c] && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("v%0d_ac_cycle", v), n, vecs[v].lat + 1);
      chk($sformatf("v%0d_rddata", v), cl_rddata, vecs[v].exp_rddata);
      chk($sformatf("v%0d_wait_ac", v), cl_wait[vecs[v].c], 0);
      set_client(vecs[v].c, 0, 0, '0, '0, '0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      chk($sformatf("v%0d_ac_once", v), cl_ac, 0);
    end
    // Real-time client 1 must win every decision while pending; rr_ptr is 4 after the table.
    @(posedge clk); #1;
    lat = 2;
    rdata_v = D_R2;
    foreach (pri_tail[i]) set_client(pri_tail[i], 1, 0, 22'(pri_tail[i]), '0, '0);
    set_client(1, 1, 0, 22'h11, '0, '0);
    for (int i = 0; i < 4; i++) begin
      wait_ac(idx);
      chk($sformatf("pri_grant%0d", i), idx, 1);
    end
    set_client(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      wait_ac(idx);
      chk($sformatf("pri_tail%0d", i), idx, pri_tail[i]);
    end
    for (int i = 0; i < N; i++) set_client(i, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    // Reset while the strobe is up: no ack, strobe gone, held request re-issued after release.
    @(posedge clk); #1;
    ack_en = 1'b0;
    lat = 2;
    rdata_v = D_R4;
    set_client(3, 1, 0, 22'h00ABC, '0, '0);
    @(posedge clk); #1;
    chk("rstmid_read_up", br.read, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_read_down", br.read, 0);
    chk("rstmid_ac", cl_ac, 0);
    chk("rstmid_busy", busy, 0);
    reset = 1'b0;
    ack_en = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_reissue", br.read, 1);
    chk("rstmid_addr", br.addr, 22'h00ABC);
    wait_ac(idx);
    chk("rstmid_grant", idx, 3);
    chk("rstmid_rddata", cl_rddata, D_R4);
    set_client(3, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    // Fresh reset so the round-robin search starts at client 2.
    do_reset();
    lat = 1;
    for (int i = 2; i < N; i++) set_client(i, 1, 0, 22'(i), '0, '0);
    for (int i = 0; i < 10; i++) begin
      wait_ac(idx);
      chk($sformatf("rr_grant%0d", i), idx, rr_exp[i]);
    end
    for (int i = 0; i < N; i++) set_client(i, 0, 0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 chk("end_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_client_arbiter.md
# sdram_client_arbiter

Arbitrates a single shared SDRAM bridge port among N clients, such as the audio streamer, line buffer, sprite/score/key-lane drawers and memory initialiser. Each client issues single-word 128-bit reads or writes with a level request/ack handshake. The block sits between those clients and the SDRAM controller's bridge slave. Real-time clients get strict fixed priority; the remaining clients share leftover bandwidth round-robin.

## Interface
- N_CLIENTS, 7, number of requesters (2..16)
- N_RT, 2, clients 0..N_RT-1 are real-time, fixed priority (0 highest); N_RT < N_CLIENTS
- AW, 22, word address width (bridge byte address = {addr,4'b0000} formed outside)
- DW, 128, data width; BEW = DW/8
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- cl_rd  in  N_CLIENTS  per-client read request (level)
- cl_wr  in  N_CLIENTS  per-client write request (level)
- cl_addr  in  N_CLIENTS*AW  flattened addresses, client i at [i*AW +: AW]
- cl_wrdata  in  N_CLIENTS*DW  flattened write data
- cl_be  in  N_CLIENTS*BEW  flattened write byte enables
- cl_ac  out  N_CLIENTS  one-cycle completion pulse to the granted client
- cl_wait  out  N_CLIENTS  request pending and not completing this cycle
- cl_rddata  out  DW  read data, broadcast, valid with cl_ac
- br_addr  out  AW  bridge word address
- br_be  out  BEW  bridge byte enable
- br_read  out  1  bridge read strobe
- br_write  out  1  bridge write strobe
- br_wrdata  out  DW  bridge write data
- br_ack  in  1  bridge acknowledge, one-cycle pulse; read data valid with it
- br_rddata  in  DW  bridge read data
- busy  out  1  transaction in flight (state != IDLE)
- grant_idx  out  4  index of the current or last granted client

## Operation
- Client rule: assert cl_rd or cl_wr and hold the request, address, data and be stable until cl_ac. Requests not held stable are undefined.
- cl_rd and cl_wr both high: treated as a write.
- States are IDLE, ISSUE and DONE.
- IDLE: if any request is pending, select a winner, latch its index, op, addr, wrdata and be, then go to ISSUE. Otherwise stay in IDLE.
- Selection: the lowest-index pending real-time client wins. If no real-time client is pending, the round-robin search starts at rr_ptr+1 over N_RT..N_CLIENTS-1, wrapping from N_CLIENTS-1 to N_RT. rr_ptr updates to the winner only on round-robin grants.
- ISSUE: br_read or br_write is held high with latched address and data until br_ack, then go to DONE. There is no timeout; the bridge must eventually acknowledge.
- Reads drive br_be = all ones; writes drive the latched cl_be.
- On br_ack during a read: capture br_rddata into cl_rddata.
- DONE: pulse cl_ac[grant_idx] for one cycle, then return to IDLE. The request the client holds during this cycle is ignored, so the client sees exactly one ack per transaction.
- cl_wait[i] = (cl_rd[i] | cl_wr[i]) & ~cl_ac[i], combinational.
- A client keeping its request high after cl_ac is re-arbitrated as a new transaction.
- cl_rddata holds its last value until the next read completes.

## Timing
- Reset values: state IDLE; br_read = br_write = 0; br_addr, br_be, br_wrdata, cl_rddata = 0; cl_ac = 0; busy = 0; grant_idx = 0; rr_ptr = N_CLIENTS-1, so the first round-robin search starts at N_RT.
- Cycle T: a request is seen in IDLE.
- Cycle T+1: the bridge strobe is high.
- Cycle A: br_ack arrives; the strobe deasserts from A+1.
- Cycle A+1: cl_ac pulses, with cl_rddata valid in the same cycle.
- Cycle A+2: the next decision is made in IDLE. The next strobe appears no earlier than A+3.
- If br_ack arrives in the first ISSUE cycle (A = T+1), cl_ac comes at T+2.
- The bridge strobe is never high in IDLE or DONE.
- Exactly one strobe is high at a time, and no more than one cl_ac bit is high at any time.
- A request dropped while in ISSUE: the transaction completes anyway and cl_ac is still pulsed.
- Reset mid-ISSUE: the strobe drops on the next edge with no cl_ac. The client must re-request.
- br_ack while in IDLE or DONE: ignored.

## Test plan
- Single read from client 3 at addr 22'h00100: br_read rises at T+1 with br_addr = 22'h00100 and br_be = 16'hFFFF. Bridge acks at T+4 with data 128'hDEAD…BEEF. Required: cl_ac[3] at T+5, cl_rddata = that data, busy low at T+6.
- Write from client 5 with be = 16'h00FF and data 128'h1234…: br_write is high with matching be and data until ack. cl_ac[5] pulses once, and cl_rddata is unchanged.
- Clients 1, 2, 4 and 6 request continuously with a 2-cycle bridge ack: client 1 is always granted first after each DONE. Clients 2, 4 and 6 are never granted while 1 is pending.
- Only clients 2..6 hold requests, with 1-cycle acks: the grant order is 2,3,4,5,6,2,3… Each client gets exactly one ack per rotation.
- Client 4 asserts both cl_rd and cl_wr: the block performs a write, and br_read stays 0.
- Reset is asserted the cycle after br_read rises: the next cycle shows br_read = 0, no cl_ac, and state IDLE. After release, the held request is re-issued at +1 cycle.
